// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared definitions for the interrupt controller.
//   - register window offsets (CTRL, PEND, MASK, VEC, EOI)
//   - CTRL bit positions and the VEC valid bit
//   - controller state encoding (visible in CTRL[5:4])
//   - decoded register-select struct
package intr_ctrl_pkg;

   localparam logic [7:0] OFF_CTRL = 8'h00;
   localparam logic [7:0] OFF_PEND = 8'h04;
   localparam logic [7:0] OFF_MASK = 8'h08;
   localparam logic [7:0] OFF_VEC  = 8'h0C;
   localparam logic [7:0] OFF_EOI  = 8'h10;

   localparam int CTRL_GIE   = 0;
   localparam int CTRL_ERR   = 1;
   localparam int CTRL_ST_LO = 4;
   localparam int CTRL_ST_HI = 5;
   localparam int VEC_VALID  = 31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_REQ   = 2'b01,
      ST_INSVC = 2'b10
   } state_t;

   // one-hot register selects decoded from ABUS
   typedef struct packed {
      logic ctrl;
      logic pend;
      logic mask;
      logic vec;
      logic eoi;
   } sel_t;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// prio_enc: fixed-priority encoder, lowest set index wins.
//   req   [NSRC-1:0] in  request vector
//   id    [7:0]      out index of the winning request (0 when none)
//   valid            out at least one request set
module prio_enc
   import intr_ctrl_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0] req,
   output logic [7:0]      id,
   output logic            valid
);

   // scan high to low so the lowest set index is the last assignment
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id    = 8'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller multiplexing device INTR
// lines onto the single CPU IRQ, with claim (VEC read) / EOI handshake.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   LOCK           clock enable; all state holds while low
//   ABUS, RE, WE   device bus address / read / write strobes
//   RBUS           read data, driven only on a decoded read, else Z
//   WBUS           write data
//   SRC            device interrupt lines (synchronous to CLK)
//   IRQ            registered interrupt request to the CPU
// Build option: define IC_EDGE_EN for per-source rising-edge latches
// (PEND cleared on claim); otherwise PEND follows SRC (level mode).
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int               ABITS = 32,
   parameter int               DBITS = 32,
   parameter logic [ABITS-1:0] RBASE = 32'hF0000100,
   parameter int               NSRC  = 4
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             LOCK,
   input  logic [ABITS-1:0] ABUS,
   inout  wire  [DBITS-1:0] RBUS,
   input  logic             RE,
   input  logic [DBITS-1:0] WBUS,
   input  logic             WE,
   input  logic [NSRC-1:0]  SRC,
   output logic             IRQ
);

   state_t            state, state_nx;
   sel_t              sel;
   logic              gie, err, irq_q;
   logic [NSRC-1:0]   mask, pend, elig;
   logic [7:0]        insvc_id, enc_id;
   logic              enc_valid;
   logic              claim, eoi_wr, eoi_ok, err_set, ctrl_wr, rd_hit;
   logic [31:0]       r32;
   logic              unused_wbus;

   assign unused_wbus = ^WBUS[DBITS-1:8];

   always_comb begin
      sel.ctrl = (ABUS == RBASE + ABITS'(OFF_CTRL));
      sel.pend = (ABUS == RBASE + ABITS'(OFF_PEND));
      sel.mask = (ABUS == RBASE + ABITS'(OFF_MASK));
      sel.vec  = (ABUS == RBASE + ABITS'(OFF_VEC));
      sel.eoi  = (ABUS == RBASE + ABITS'(OFF_EOI));
   end

   assign elig = pend & mask;

   prio_enc #(.NSRC(NSRC)) u_prio (
      .req   (elig),
      .id    (enc_id),
      .valid (enc_valid)
   );

   // claim: VEC read while requesting; uses the pre-edge eligible set
   assign claim   = LOCK & RE & sel.vec & (state == ST_REQ) & enc_valid;
   assign eoi_wr  = LOCK & WE & sel.eoi;
   assign eoi_ok  = eoi_wr & (state == ST_INSVC) & (WBUS[7:0] == insvc_id);
   assign err_set = eoi_wr & ~eoi_ok;
   assign ctrl_wr = LOCK & WE & sel.ctrl;

`ifdef IC_EDGE_EN
   logic [NSRC-1:0] pend_q, src_q, clr;

   assign clr  = claim ? (NSRC'(1) << enc_id) : '0;
   assign pend = pend_q;

   // a new rising edge outranks a claim clear on the same bit
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pend_q <= '0;
         src_q  <= '0;
      end else if (LOCK) begin
         src_q  <= SRC;
         pend_q <= (pend_q & ~clr) | (SRC & ~src_q);
      end
   end
`else
   assign pend = SRC;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (gie && enc_valid) state_nx = ST_REQ;
         ST_REQ: begin
            if (claim)                   state_nx = ST_INSVC;
            else if (!enc_valid || !gie) state_nx = ST_IDLE;
         end
         ST_INSVC: if (eoi_ok) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= ST_IDLE;
         irq_q    <= 1'b0;
         gie      <= 1'b0;
         err      <= 1'b0;
         mask     <= '0;
         insvc_id <= '0;
      end else if (LOCK) begin
         state <= state_nx;
         irq_q <= (state_nx == ST_REQ);
         if (claim) insvc_id <= enc_id;
         if (ctrl_wr) gie <= WBUS[CTRL_GIE];
         if (WE && sel.mask) mask <= WBUS[NSRC-1:0];
         // hardware set beats software clear; writing 1 never sets
         if (err_set)                      err <= 1'b1;
         else if (ctrl_wr && !WBUS[CTRL_ERR]) err <= 1'b0;
      end
   end

   assign IRQ = irq_q;

   // reads answer from held state even while LOCK is low
   always_comb begin
      r32 = '0;
      if (sel.ctrl) begin
         r32[CTRL_GIE]              = gie;
         r32[CTRL_ERR]              = err;
         r32[CTRL_ST_HI:CTRL_ST_LO] = state;
      end
      if (sel.pend) r32[NSRC-1:0] = pend;
      if (sel.mask) r32[NSRC-1:0] = mask;
      if (sel.vec && state == ST_REQ && enc_valid) begin
         r32[VEC_VALID] = 1'b1;
         r32[7:0]       = enc_id;
      end
   end

   assign rd_hit = RE & (sel.ctrl | sel.pend | sel.mask | sel.vec);
   assign RBUS   = rd_hit ? DBITS'(r32) : {DBITS{1'bz}};

endmodule
